// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// ----------------------------------------------------------------------------
// Bridges a single-request CPU access port to a 32-bit RAM that uses a
// return-to-zero ram_mfc handshake.
//
// Byte, halfword and word accesses take one RAM transaction. A doubleword
// access takes two word transactions: the first is at address with
// wdata[63:32], and the second is at (address+4) mod 512 with wdata[31:0].
//
// Each transaction runs through three states:
//   SETUP   - the RAM is idle while its address and data settle.
//   ACCESS  - ram_enable is high until ram_mfc=1.
//   RELEASE - ram_enable is low until ram_mfc=0.
// A watchdog limits each wait on an mfc edge to TIMEOUT_CYCLES cycles.
//
// Optional feature: define MEM_ACCESS_CTRL_ALIGN_CHECK_EN to reject
// misaligned halfword, word and doubleword requests. A rejected request
// completes with error=1 and makes no RAM transaction.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   req                   : access request (sampled only when idle)
//   read_write            : 1 = read, 0 = write
//   data_length           : 0 byte, 1 halfword, 2 word, 3 doubleword
//   address [8:0]         : byte address
//   wdata [63:0]          : write data ([63:32] is the first doubleword word)
//   rdata [63:0]          : read data, zero-extended, held until next read
//   busy / done / error   : status; done pulses once, error is valid with done
//   ram_enable, ram_read_write, ram_data_length, ram_address, ram_data_in,
//   ram_data_out, ram_mfc : RAM-side handshake interface
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        read_write,
    input  logic [1:0]  data_length,
    input  logic [8:0]  address,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ram_enable,
    output logic        ram_read_write,
    output logic [1:0]  ram_data_length,
    output logic [8:0]  ram_address,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    input  logic        ram_mfc
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RELEASE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_rw;
    logic [1:0]       r_len;
    logic [8:0]       r_addr;
    logic [63:0]      r_wdata;
    logic             r_second;   // currently on the second doubleword word
    logic             r_error;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_rbuf;     // assembles read data before it is published
    logic [63:0]      r_rdata;

    logic w_accept;
    logic w_misaligned;
    logic w_align_err;
    logic w_capture;
    logic w_timeout;
    logic w_cnt_clr;
    logic w_to_second;
    logic w_finish;
    logic w_is_dword;

    assign w_is_dword = (r_len == 2'd3);

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (data_length)
            2'd1:    w_misaligned = address[0];
            2'd2:    w_misaligned = (address[1:0] != 2'd0);
            2'd3:    w_misaligned = (address[2:0] != 3'd0);
            default: w_misaligned = 1'b0;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_align_err  = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_to_second  = 1'b0;
        w_finish     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        ram_enable   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (w_misaligned) begin
                        w_align_err  = 1'b1;
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                busy         = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                busy       = 1'b1;
                ram_enable = 1'b1;
                if (ram_mfc) begin
                    w_capture    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = S_RELEASE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RELEASE: begin
                busy = 1'b1;
                if (!ram_mfc) begin
                    if (w_is_dword && !r_second) begin
                        w_to_second  = 1'b1;
                        w_next_state = S_SETUP;
                    end else begin
                        w_finish     = 1'b1;
                        w_next_state = S_RESP;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                done         = 1'b1;
                error        = r_error;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch, watchdog and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rw     <= 1'b0;
            r_len    <= 2'd0;
            r_addr   <= 9'd0;
            r_wdata  <= 64'd0;
            r_second <= 1'b0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
            r_rbuf   <= 64'd0;
            r_rdata  <= 64'd0;
        end else begin
            if (w_accept) begin
                r_rw     <= read_write;
                r_len    <= data_length;
                r_addr   <= address;
                r_wdata  <= wdata;
                r_second <= 1'b0;
                r_error  <= w_align_err;
            end
            if (w_to_second) begin
                r_second <= 1'b1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state == S_ACCESS || r_state == S_RELEASE) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= '0;
            end

            if (w_capture && r_rw) begin
                case (r_len)
                    2'd0: r_rbuf <= {56'd0, ram_data_out[7:0]};
                    2'd1: r_rbuf <= {48'd0, ram_data_out[15:0]};
                    2'd2: r_rbuf <= {32'd0, ram_data_out};
                    default: begin
                        if (!r_second) begin
                            r_rbuf <= {ram_data_out, 32'd0};
                        end else begin
                            r_rbuf[31:0] <= ram_data_out;
                        end
                    end
                endcase
            end

            // rdata changes only when a read completes successfully, so it
            // stays stable across writes, timeouts and rejected requests.
            if (w_finish && r_rw) begin
                r_rdata <= r_rbuf;
            end
        end
    end

    assign rdata           = r_rdata;
    assign ram_read_write  = r_rw;
    assign ram_data_length = w_is_dword ? 2'd2 : r_len;
    assign ram_address     = r_second ? (r_addr + 9'd4) : r_addr;
    assign ram_data_in     = (w_is_dword && !r_second) ? r_wdata[63:32] : r_wdata[31:0];

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        read_write;
    logic [1:0]  data_length;
    logic [8:0]  address;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        ram_enable;
    logic        ram_read_write;
    logic [1:0]  ram_data_length;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic        ram_mfc;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .read_write      (read_write),
        .data_length     (data_length),
        .address         (address),
        .wdata           (wdata),
        .rdata           (rdata),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .ram_enable      (ram_enable),
        .ram_read_write  (ram_read_write),
        .ram_data_length (ram_data_length),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_data_out    (ram_data_out),
        .ram_mfc         (ram_mfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (byte array, little-endian within a word)
    logic [7:0] ram [512];
    int         en_cnt;
    int         tb_delay = 0;
    logic       tb_stuck = 1'b0;

    assign ram_mfc = ram_enable && !tb_stuck && (en_cnt >= tb_delay);

    always_comb begin
        ram_data_out = 32'd0;
        for (int i = 0; i < 4; i++) begin
            logic [8:0] a;
            a = ram_address + 9'(i);
            if (i < (1 << ram_data_length)) ram_data_out[8*i +: 8] = ram[a];
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'd0;
            en_cnt <= 0;
        end else begin
            en_cnt <= ram_enable ? en_cnt + 1 : 0;
            if (ram_enable && ram_mfc && !ram_read_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < (1 << ram_data_length)) ram[ram_address + 9'(i)] <= ram_data_in[8*i +: 8];
                end
            end
        end
    end

    // ---------------- RAM-bus monitor: one record per ram_enable pulse
    typedef struct {
        logic [8:0]  addr;
        logic [1:0]  len;
        logic        rw;
        logic [31:0] din;
    } txn_t;
    txn_t mon_q[$];
    logic prev_en = 1'b0;
    int   stab_err = 0;
    txn_t last_t;

    always @(posedge clk) begin
        prev_en <= ram_enable;
        if (ram_enable && !prev_en) begin
            txn_t t;
            t.addr = ram_address; t.len = ram_data_length;
            t.rw = ram_read_write; t.din = ram_data_in;
            mon_q.push_back(t);
            last_t <= t;
        end else if (ram_enable && prev_en) begin
            if (ram_address !== last_t.addr || ram_data_length !== last_t.len ||
                ram_read_write !== last_t.rw || ram_data_in !== last_t.din)
                stab_err <= stab_err + 1;
        end
    end

    // ---------------- Reference model: byte-level golden memory
    logic [7:0]  gmem [512];
    logic [63:0] model_rdata;

    function automatic logic model_mis(input logic [1:0] len, input logic [8:0] a);
        logic m;
        case (len)
            2'd1:    m = a[0];
            2'd2:    m = (a[1:0] != 2'd0);
            2'd3:    m = (a[2:0] != 3'd0);
            default: m = 1'b0;
        endcase
        return ALIGN_EN && m;
    endfunction

    function automatic logic [31:0] g_word(input logic [8:0] a, input int nbytes);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = gmem[(int'(a) + i) % 512];
        return r;
    endfunction

    function automatic logic [63:0] g_read(input logic [1:0] len, input logic [8:0] a);
        if (len == 2'd3) return {g_word(a, 4), g_word(9'(int'(a) + 4), 4)};
        return {32'd0, g_word(a, 1 << len)};
    endfunction

    task automatic g_write(input logic [1:0] len, input logic [8:0] a, input logic [63:0] wd);
        if (len == 2'd3) begin
            for (int i = 0; i < 4; i++) gmem[(int'(a) + i) % 512] = wd[32 + 8*i +: 8];
            for (int i = 0; i < 4; i++) gmem[(int'(a) + 4 + i) % 512] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < (1 << len); i++) gmem[(int'(a) + i) % 512] = wd[8*i +: 8];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete request; latency counted in cycles from the accepting edge.
    task automatic run_access(input string tag, input logic rw, input logic [1:0] len,
                              input logic [8:0] addr, input logic [63:0] wd,
                              input int exp_lat, input logic exp_err,
                              input logic [63:0] exp_rd, input int exp_pulses);
        int lat;
        mon_q.delete();
        @(negedge clk);
        req = 1'b1; read_write = rw; data_length = len; address = addr; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        if (exp_lat > 1) chk({tag, " busy"}, 64'(busy), 64'd1);
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " done seen"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " rdata"}, rdata, exp_rd);
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
        chk({tag, " ram_enable at done"}, 64'(ram_enable), 64'd0);
        chk({tag, " pulses"}, 64'(mon_q.size()), 64'(exp_pulses));
        for (int i = 0; i < mon_q.size() && i < 2; i++) begin
            logic [8:0]  ea;
            logic [31:0] ed;
            ea = (i == 0) ? addr : 9'(int'(addr) + 4);
            ed = (len == 2'd3 && i == 0) ? wd[63:32] : wd[31:0];
            chk({tag, " ram_address"}, 64'(mon_q[i].addr), 64'(ea));
            chk({tag, " ram_len"}, 64'(mon_q[i].len), 64'((len == 2'd3) ? 2'd2 : len));
            chk({tag, " ram_rw"}, 64'(mon_q[i].rw), 64'(rw));
            if (!rw) chk({tag, " ram_data_in"}, 64'(mon_q[i].din), 64'(ed));
        end
        @(negedge clk);
        chk({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  len;
        logic [8:0]  addr;
        logic [63:0] wd;
        int          lat;
        logic        err;
        logic [63:0] rd;
        int          pulses;
    } vec_t;
    vec_t vecs[8];

    initial begin
        req = 0; read_write = 0; data_length = 0; address = 0; wdata = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 512; i++) gmem[i] = 8'd0;
        model_rdata = 64'd0;

        vecs[0] = '{1'b0, 2'd2, 9'h010, 64'h00000000DEADBEEF, 4, 1'b0, 64'h0, 1};
        vecs[1] = '{1'b1, 2'd2, 9'h010, 64'h0, 4, 1'b0, 64'h00000000DEADBEEF, 1};
        vecs[2] = '{1'b0, 2'd3, 9'h1F8, 64'h1122334455667788, 7, 1'b0, 64'h00000000DEADBEEF, 2};
        vecs[3] = '{1'b1, 2'd3, 9'h1F8, 64'h0, 7, 1'b0, 64'h1122334455667788, 2};
        vecs[4] = '{1'b0, 2'd0, 9'h003, 64'h00000000000000A5, 4, 1'b0, 64'h1122334455667788, 1};
        vecs[5] = '{1'b1, 2'd0, 9'h003, 64'h0, 4, 1'b0, 64'h00000000000000A5, 1};
        vecs[6] = '{1'b1, 2'd1, 9'h010, 64'h0, 4, 1'b0, 64'h000000000000BEEF, 1};
        if (ALIGN_EN) vecs[7] = '{1'b1, 2'd2, 9'h002, 64'h0, 1, 1'b1, 64'h000000000000BEEF, 0};
        else          vecs[7] = '{1'b1, 2'd2, 9'h002, 64'h0, 4, 1'b0, 64'h000000000000A500, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset error", 64'(error), 64'd0);
        chk("reset ram_enable", 64'(ram_enable), 64'd0);
        chk("reset rdata", rdata, 64'd0);
        chk("reset ram_address", 64'(ram_address), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            run_access($sformatf("vec%0d", v), vecs[v].rw, vecs[v].len, vecs[v].addr, vecs[v].wd,
                       vecs[v].lat, vecs[v].err, vecs[v].rd, vecs[v].pulses);
            if (!vecs[v].rw && !model_mis(vecs[v].len, vecs[v].addr))
                g_write(vecs[v].len, vecs[v].addr, vecs[v].wd);
        end
        model_rdata = vecs[7].rd;

        // req held/pulsed while busy must not start another transaction
        begin
            int lat;
            mon_q.delete();
            @(negedge clk);
            req = 1'b1; read_write = 1'b1; data_length = 2'd0; address = 9'h003; wdata = 64'h0;
            @(negedge clk);
            read_write = 1'b0; data_length = 2'd2; address = 9'h010; wdata = 64'hFFFFFFFFFFFFFFFF;
            lat = 1;
            @(negedge clk); lat++;
            @(negedge clk); lat++;
            req = 1'b0;
            while (!done && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            chk("busyreq latency", 64'(lat), 64'd4);
            chk("busyreq rdata", rdata, 64'h00000000000000A5);
            repeat (3) @(negedge clk);
            chk("busyreq pulses", 64'(mon_q.size()), 64'd1);
            chk("busyreq idle", 64'(busy), 64'd0);
            model_rdata = 64'h00000000000000A5;
        end

        // Timeout: mfc never rises
        tb_stuck = 1'b1;
        run_access("timeout", 1'b1, 2'd2, 9'h010, 64'h0, 66, 1'b1, model_rdata, 1);
        tb_stuck = 1'b0;
        run_access("after timeout", 1'b1, 2'd2, 9'h010, 64'h0, 4, 1'b0, 64'h00000000DEADBEEF, 1);
        model_rdata = 64'h00000000DEADBEEF;

        // Randomized accesses against the golden memory
        for (int n = 0; n < 150; n++) begin
            logic        rw;
            logic [1:0]  len;
            logic [8:0]  a;
            logic [63:0] wd;
            logic        mis;
            int          d;
            int          lat;
            logic [63:0] erd;
            rw  = 1'($urandom);
            len = 2'($urandom);
            a   = 9'($urandom);
            wd  = {$urandom, $urandom};
            d   = $urandom_range(0, 3);
            mis = model_mis(len, a);
            tb_delay = d;
            lat = mis ? 1 : ((len == 2'd3) ? 7 + 2 * d : 4 + d);
            erd = (rw && !mis) ? g_read(len, a) : model_rdata;
            run_access($sformatf("rnd%0d", n), rw, len, a, wd, lat, mis, erd,
                       mis ? 0 : ((len == 2'd3) ? 2 : 1));
            if (!mis) begin
                if (rw) model_rdata = erd;
                else    g_write(len, a, wd);
            end
        end
        tb_delay = 0;

        // Reset during the second doubleword ACCESS
        begin
            int n;
            mon_q.delete();
            tb_delay = 10;
            @(negedge clk);
            req = 1'b1; read_write = 1'b0; data_length = 2'd3; address = 9'h100;
            wdata = 64'hAAAABBBBCCCCDDDD;
            @(negedge clk);
            req = 1'b0;
            n = 0;
            while (mon_q.size() < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("rst second access reached", 64'(mon_q.size()), 64'd2);
            chk("rst enable before", 64'(ram_enable), 64'd1);
            reset_n = 1'b0;
            #1;
            chk("rst ram_enable", 64'(ram_enable), 64'd0);
            chk("rst busy", 64'(busy), 64'd0);
            chk("rst done", 64'(done), 64'd0);
            chk("rst rdata", rdata, 64'd0);
            chk("rst ram_address", 64'(ram_address), 64'd0);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            tb_delay = 0;
            @(negedge clk);
            run_access("post-rst wr", 1'b0, 2'd2, 9'h040, 64'h00000000CAFEF00D, 4, 1'b0, 64'd0, 1);
            run_access("post-rst rd", 1'b1, 2'd2, 9'h040, 64'h0, 4, 1'b0, 64'h00000000CAFEF00D, 1);
        end

        chk("ram outputs stable during enable", 64'(stab_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
